uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter with an input FIFO, runtime baud prescaler, and runtime-selectable parity and stop-bit count. It sits between a parallel producer using a valid/ready handshake and the serial TX line. It replaces the fixed one-clock-per-bit, single-word transmitter in the UART subsystem. Frames queued in the FIFO are sent back-to-back with no idle gap.

## Interface
- WIDTH, 8: data bits per frame; legal range 5–9.
- FIFO_DEPTH, 4: input FIFO entries; power of two, at least 2.
- PRESCALE_W, 16: width of the PRESCALE port.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- DATA_VALID  in  1  producer has a word on P_DATA.
- DATA_READY  out  1  FIFO can accept a word. Equals !full; forced to 0 while RST is high.
- P_DATA  in  WIDTH  word to send; bit 0 is transmitted first.
- PAR_EN  in  1  1 = append a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  0 = one stop bit, 1 = two stop bits.
- PRESCALE  in  PRESCALE_W  CLK cycles per bit; a value of 0 is treated as 1.
- TX_OUT  out  1  serial line, registered; idles at 1.
- Busy  out  1  high while the FSM is in any state other than IDLE.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO.

## Operation
- Push: on an edge where DATA_VALID && DATA_READY, write P_DATA into the FIFO.
  - DATA_VALID while DATA_READY=0 is not accepted; the producer holds the word.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_OUT=1. If the FIFO is non-empty:
    - pop the FIFO into the shift register;
    - latch PAR_EN, PAR_TYP, STOP2 and max(PRESCALE,1);
    - compute the parity bit as ^word XOR PAR_TYP;
    - go to START.
  - START: TX_OUT=0 for one bit time, then go to DATA.
  - DATA: send WIDTH bits LSB first, one bit time each, tracked by a bit index counter. After the last bit, go to PARITY if the latched PAR_EN is 1, otherwise go to STOP.
  - PARITY: TX_OUT=parity bit for one bit time, then go to STOP.
  - STOP: TX_OUT=1 for one bit time, or two if STOP2 was latched. At the last cycle of the stop period:
    - if the FIFO is non-empty, pop it, re-latch the config, and go directly to START;
    - otherwise go to IDLE.
- Bit time: a down-counter loads the latched prescale value minus 1 and counts to 0. The state or bit advances on the cycle the counter reads 0.
- Config inputs may change at any time. They affect only frames that start after the change.
- Frame length in CLK cycles: P × (2 + WIDTH + PAR_EN + STOP2), where P = max(PRESCALE,1).
- FIFO corner cases:
  - push and pop on the same edge: both happen and FIFO_COUNT is unchanged;
  - when full, DATA_READY=0; a pop on that edge makes DATA_READY=1 on the next cycle;
  - a pop is never issued when the FIFO is empty.
- Pointers wrap modulo FIFO_DEPTH. FIFO_COUNT runs from 0 to FIFO_DEPTH.

## Timing
- Reset values: TX_OUT=1, Busy=0, FIFO_COUNT=0, state=IDLE, all counters 0. DATA_READY=0 during RST and 1 on the first cycle after reset.
- Reset mid-frame: the frame is aborted and the FIFO is flushed. TX_OUT=1 from the edge on which RST is sampled high.
- Latency: a word accepted at edge k, with the FSM idle and the FIFO empty, is popped at edge k+1.
  - TX_OUT=0 and Busy=1 from edge k+1.
  - FIFO_COUNT reads 1 for exactly one cycle.
- Back-to-back frames: the start bit of frame n+1 begins on the cycle immediately after the last stop-bit cycle of frame n. There is no idle cycle between them.
- Busy falls at the edge where STOP exits to IDLE. TX_OUT stays 1 across that transition.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum uart_tx_state_t;
  - constants PAR_EVEN=0 and PAR_ODD=1;
  - function uart_frame_bits(width, par_en, stop2), used by the bench for cycle accounting.
- Sub-module uart_tx_fifo: a synchronous FIFO with full/empty flags and a count output, parameterised on WIDTH and FIFO_DEPTH. The FSM, shift register, prescale counter and parity logic are in the top level.

## Test plan
- Basic frame. WIDTH=8, PRESCALE=1, PAR_EN=0, STOP2=0, push 0xA5 → TX_OUT shows 0,1,0,1,0,0,1,0,1,1 over 10 cycles; Busy is high for exactly 10 cycles.
- Parity and stop bits. PRESCALE=4, PAR_EN=1, PAR_TYP=1, STOP2=1, push 0x03 → the parity bit is 1 (odd parity), there are two stop bits, each bit lasts 4 cycles, and the frame is 48 cycles long.
- Back-to-back and full FIFO. FIFO_DEPTH=4, PRESCALE=2, push 6 words continuously → DATA_READY drops to 0 with FIFO_COUNT=4; all 6 frames go out contiguously with no idle cycle between them; the received order matches the push order.
- PRESCALE=0 is treated as 1. Changing PRESCALE from 3 to 5 mid-frame → the current frame keeps 3-cycle bits and the next frame uses 5-cycle bits.
- Reset mid-frame. Assert RST during the DATA state with 2 words queued → TX_OUT=1, Busy=0, FIFO_COUNT=0 on the next cycle; no further frames are sent.
- Same-edge push and pop. Push exactly on the STOP→START pop edge with FIFO_COUNT=2 → FIFO_COUNT stays 2 and no word is lost or duplicated.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and helpers for the UART transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Bit periods in one frame: start + data + optional parity + one or two stops.
  function automatic int unsigned uart_frame_bits(input int unsigned width,
                                                  input logic par_en,
                                                  input logic stop2);
    return 32'd2 + width + {31'd0, par_en} + {31'd0, stop2};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Synchronous first-word-fall-through FIFO with full/empty/count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wr_en,
  input  logic [WIDTH-1:0]              i_wr_data,
  input  logic                          i_rd_en,
  output logic [WIDTH-1:0]              o_rd_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Brief    : FIFO-fed UART transmitter with runtime prescale, parity, stop bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          DATA_VALID,
  output logic                          DATA_READY,
  input  logic [WIDTH-1:0]              P_DATA,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [PRESCALE_W-1:0]         PRESCALE,
  output logic                          TX_OUT,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int               IDXW     = $clog2(WIDTH);
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(WIDTH - 1);

  uart_tx_state_t         r_state;
  logic [WIDTH-1:0]       r_shift;
  logic [IDXW-1:0]        r_bit_idx;
  logic [PRESCALE_W-1:0]  r_cnt;
  logic [PRESCALE_W-1:0]  r_presc;
  logic                   r_par_en;
  logic                   r_par_bit;
  logic                   r_stop2;
  logic                   r_stop_idx;
  logic                   r_tx;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_tick;
  logic                   w_stop_last;
  logic [WIDTH-1:0]       w_fifo_data;
  logic [PRESCALE_W-1:0]  w_presc;

  assign DATA_READY  = !RST && !w_full;
  assign w_push      = DATA_VALID && DATA_READY;
  assign w_tick      = (r_cnt == '0);
  assign w_stop_last = (r_state == ST_STOP) && w_tick && (!r_stop2 || r_stop_idx);
  // Popping at the final stop cycle is what makes queued frames contiguous.
  assign w_pop       = !RST && !w_empty && ((r_state == ST_IDLE) || w_stop_last);
  assign w_presc     = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
  assign TX_OUT      = r_tx;
  assign Busy        = (r_state != ST_IDLE);

  uart_tx_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .i_wr_en   (w_push),
    .i_wr_data (P_DATA),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (FIFO_COUNT)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_cnt      <= '0;
      r_presc    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
    end else if (w_pop) begin
      r_state    <= ST_START;
      r_shift    <= w_fifo_data;
      r_bit_idx  <= '0;
      r_par_en   <= PAR_EN;
      r_par_bit  <= (^w_fifo_data) ^ (PAR_TYP == PAR_ODD);
      r_stop2    <= STOP2;
      r_stop_idx <= 1'b0;
      r_presc    <= w_presc;
      r_cnt      <= w_presc - PRESCALE_W'(1);
      r_tx       <= 1'b0;
    end else if (r_state != ST_IDLE) begin
      if (!w_tick) begin
        r_cnt <= r_cnt - PRESCALE_W'(1);
      end else begin
        r_cnt <= r_presc - PRESCALE_W'(1);
        case (r_state)
          ST_START: begin
            r_state   <= ST_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
          end
          ST_DATA: begin
            if (r_bit_idx == LAST_IDX) begin
              r_stop_idx <= 1'b0;
              if (r_par_en) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
          ST_PARITY: begin
            r_state    <= ST_STOP;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
          end
          ST_STOP: begin
            if (r_stop2 && !r_stop_idx) begin
              r_stop_idx <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
            r_tx <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Brief    : Self-checking bench for uart_tx_frame against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int PW = 16;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           DATA_VALID = 1'b0;
  logic [W-1:0]   P_DATA = '0;
  logic           PAR_EN = 1'b0;
  logic           PAR_TYP = 1'b0;
  logic           STOP2 = 1'b0;
  logic [PW-1:0]  PRESCALE = 16'd1;
  logic           DATA_READY;
  logic           TX_OUT;
  logic           Busy;
  logic [$clog2(D):0] FIFO_COUNT;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame #(
    .WIDTH      (W),
    .FIFO_DEPTH (D),
    .PRESCALE_W (PW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .P_DATA     (P_DATA),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .PRESCALE   (PRESCALE),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .FIFO_COUNT (FIFO_COUNT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a word queue plus the per-cycle line waveform of the
  // frame in flight; a new frame is expanded whenever the waveform runs out.
  logic [W-1:0] mq[$];
  logic         wave[$];
  logic         e_tx, e_busy, e_ready;
  int           e_cnt;

  function automatic void build_frame(input logic [W-1:0] w);
    int   p = (PRESCALE == 0) ? 1 : int'(PRESCALE);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(w[i]);
    if (PAR_EN) bits.push_back((^w) ^ PAR_TYP);
    bits.push_back(1'b1);
    if (STOP2) bits.push_back(1'b1);
    foreach (bits[i]) repeat (p) wave.push_back(bits[i]);
  endfunction

  always @(posedge CLK) begin
    logic acc;
    if (RST) begin
      mq.delete();
      wave.delete();
    end else begin
      acc = DATA_VALID && (mq.size() < D);
      if (wave.size() > 0) wave.delete(0);
      if (wave.size() == 0 && mq.size() > 0) build_frame(mq.pop_front());
      if (acc) mq.push_back(P_DATA);
    end
    e_busy  = (wave.size() > 0);
    e_tx    = e_busy ? wave[0] : 1'b1;
    e_cnt   = mq.size();
    e_ready = !RST && (mq.size() < D);
    #1;
    chk("tx_out", {31'd0, TX_OUT}, {31'd0, e_tx});
    chk("busy", {31'd0, Busy}, {31'd0, e_busy});
    chk("fifo_count", 32'(FIFO_COUNT), e_cnt);
    chk("data_ready", {31'd0, DATA_READY}, {31'd0, e_ready});
  end

  int run_len = 0, last_run = 0, busy_total = 0;
  bit saw_full = 1'b0;
  always @(negedge CLK) begin
    if (Busy === 1'b1) begin
      run_len++;
      busy_total++;
    end else if (run_len > 0) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (!RST && DATA_READY === 1'b0 && FIFO_COUNT == D) saw_full = 1'b1;
  end

  task automatic push_word(input logic [W-1:0] d);
    int g = 0;
    @(negedge CLK);
    DATA_VALID = 1'b1;
    P_DATA     = d;
    #1;
    while (DATA_READY !== 1'b1 && g < 2000) begin
      @(negedge CLK);
      #1;
      g++;
    end
    chk("push_wait_bound", {31'd0, g < 2000}, 32'd1);
    @(posedge CLK);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((Busy !== 1'b0 || FIFO_COUNT != 0) && n < 3000);
    chk({name, "_idle_bound"}, {31'd0, n < 3000}, 32'd1);
    @(negedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  v10;
    logic [11:0] v12;
    logic        s48[48];
    int          unsteady;

    repeat (3) @(negedge CLK);
    chk("ready_in_reset", {31'd0, DATA_READY}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_reset_ready", {31'd0, DATA_READY}, 32'd1);
    chk("post_reset_tx", {31'd0, TX_OUT}, 32'd1);
    chk("post_reset_busy", {31'd0, Busy}, 32'd0);
    chk("post_reset_count", 32'(FIFO_COUNT), 32'd0);

    // Basic frame, 0xA5 at one clock per bit
    PRESCALE = 16'd1; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN; STOP2 = 1'b0;
    push_word(8'hA5);
    @(negedge CLK); DATA_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      v10[i] = TX_OUT;
    end
    chk("basic_bits", {22'd0, v10}, 32'h34A);
    wait_idle("basic");
    chk("basic_len", last_run, 32'd10);

    // Odd parity, two stop bits, four clocks per bit
    PRESCALE = 16'd4; PAR_EN = 1'b1; PAR_TYP = PAR_ODD; STOP2 = 1'b1;
    push_word(8'h03);
    @(negedge CLK); DATA_VALID = 1'b0;
    for (int i = 0; i < 48; i++) begin
      @(negedge CLK);
      s48[i] = TX_OUT;
    end
    unsteady = 0;
    for (int i = 0; i < 48; i++) if (s48[i] !== s48[(i / 4) * 4]) unsteady++;
    for (int b = 0; b < 12; b++) v12[b] = s48[4 * b];
    chk("par_bits", {20'd0, v12}, 32'hE06);
    chk("par_parity_bit", {31'd0, v12[9]}, 32'd1);
    chk("par_bit_steady", unsteady, 32'd0);
    wait_idle("parity");
    chk("par_len", last_run, 32'd48);

    // Back-to-back frames through a full FIFO
    PRESCALE = 16'd2; PAR_EN = 1'b0; STOP2 = 1'b0; saw_full = 1'b0;
    for (int i = 0; i < 6; i++) push_word(W'($urandom));
    @(negedge CLK); DATA_VALID = 1'b0;
    wait_idle("b2b");
    chk("b2b_full_seen", {31'd0, saw_full}, 32'd1);
    chk("b2b_len", last_run, 6 * 2 * uart_frame_bits(W, 1'b0, 1'b0));

    // Prescale of zero behaves as one
    PRESCALE = 16'd0;
    push_word(W'($urandom));
    @(negedge CLK); DATA_VALID = 1'b0;
    wait_idle("presc0");
    chk("presc0_len", last_run, 32'd10);

    // Prescale change mid-frame applies only to the next frame
    PRESCALE = 16'd3;
    push_word(W'($urandom));
    push_word(W'($urandom));
    @(negedge CLK); DATA_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    PRESCALE = 16'd5;
    wait_idle("presc_chg");
    chk("presc_chg_len", last_run, 32'd80);

    // Reset during the data bits with two words queued
    PRESCALE = 16'd4;
    for (int i = 0; i < 3; i++) push_word(W'($urandom));
    @(negedge CLK); DATA_VALID = 1'b0;
    repeat (8) @(negedge CLK);
    chk("rst_pre_count", 32'(FIFO_COUNT), 32'd2);
    chk("rst_pre_busy", {31'd0, Busy}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_tx", {31'd0, TX_OUT}, 32'd1);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_count", 32'(FIFO_COUNT), 32'd0);
    chk("rst_ready", {31'd0, DATA_READY}, 32'd0);
    RST = 1'b0;
    busy_total = 0;
    repeat (100) @(negedge CLK);
    chk("rst_no_frames", busy_total, 32'd0);
    chk("rst_count_after", 32'(FIFO_COUNT), 32'd0);

    // Push on the same edge as the stop-to-start pop
    PRESCALE = 16'd1;
    for (int i = 0; i < 3; i++) push_word(W'($urandom));
    @(negedge CLK); DATA_VALID = 1'b0;
    repeat (7) @(negedge CLK);
    chk("same_edge_pre_count", 32'(FIFO_COUNT), 32'd2);
    push_word(W'($urandom));
    @(negedge CLK); DATA_VALID = 1'b0;
    chk("same_edge_count", 32'(FIFO_COUNT), 32'd2);
    chk("same_edge_start_bit", {31'd0, TX_OUT}, 32'd0);
    wait_idle("same_edge");
    chk("same_edge_len", last_run, 32'd40);

    // Randomised traffic, config churn and occasional resets
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 7) == 0) begin
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        STOP2    = 1'($urandom);
        PRESCALE = PW'($urandom_range(0, 4));
      end
      DATA_VALID = ($urandom_range(0, 3) != 0);
      P_DATA     = W'($urandom);
      RST        = ($urandom_range(0, 499) == 0);
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    RST        = 1'b0;
    wait_idle("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
